// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF and DM requester ports, the shared memory port and stall.
// The slave modport is the arbiter's view; master is the fetch/LSU/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           mem_gnt, mem_rvalid, mem_rdata,
    output if_valid, if_rdata, dm_valid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           mem_gnt, mem_rvalid, mem_rdata,
    input  if_valid, if_rdata, dm_valid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and load/store.
// DM has priority; a starvation counter forces an IF grant after STARVE_MAX contested DM grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.slave   bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;

  logic if_starved;
  assign if_starved = bus.if_req && (starve_cnt_q == STARVE_LIM);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    case (state_q)
      IDLE: begin
        if (bus.dm_req && !if_starved) begin
          owner_d     = OWN_DM;
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_be_d    = bus.dm_be;
          // Reaching here with if_req set implies the counter is below the limit.
          starve_cnt_d = bus.if_req ? starve_cnt_q + 1'b1 : '0;
        end else if (bus.if_req) begin
          owner_d      = OWN_IF;
          state_d      = REQ;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          mem_be_d     = '1;
          starve_cnt_d = '0;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
        end
      end
      RESP: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d   = IDLE;
        owner_d   = OWN_NONE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
    end
  end

  // Responses only count in RESP, so an rvalid alongside mem_gnt or after reset is dropped.
  logic resp_hit;
  assign resp_hit = (state_q == RESP) && bus.mem_rvalid;

  assign bus.if_valid  = resp_hit && (owner_q == OWN_IF);
  assign bus.dm_valid  = resp_hit && (owner_q == OWN_DM);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.stall     = (bus.if_req & ~bus.if_valid) | (bus.dm_req & ~bus.dm_valid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the grant edge (arbiter in REQ). Holds mem_gnt low for
  // gnt_delay cycles, then gnt, then rvalid; returns one step after the edge that
  // ends the response cycle, i.e. in the next arbitration cycle.
  task automatic serve(input bit is_dm, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int gnt_delay);
    for (int k = 0; k <= gnt_delay; k++) begin
      bus.mem_gnt = (k == gnt_delay);
      @(negedge clk);
      chk("req_mem_req",   bus.mem_req,   1'b1);
      chk("req_mem_addr",  bus.mem_addr,  addr);
      chk("req_mem_we",    bus.mem_we,    we);
      chk("req_mem_be",    bus.mem_be,    be);
      chk("req_mem_wdata", bus.mem_wdata, wdata);
      chk("req_no_valid",  {bus.if_valid, bus.dm_valid}, 2'b00);
      tick();
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    @(negedge clk);
    chk("resp_mem_req", bus.mem_req,  1'b0);
    chk("resp_if_valid", bus.if_valid, !is_dm);
    chk("resp_dm_valid", bus.dm_valid, is_dm);
    chk("resp_rdata", is_dm ? bus.dm_rdata : bus.if_rdata, rdata);
    chk("resp_stall", bus.stall, is_dm ? bus.if_req : bus.dm_req);
    tick();
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;

    @(negedge clk);
    chk("rst_mem_req",  bus.mem_req,  1'b0);
    chk("rst_mem_we",   bus.mem_we,   1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be",   bus.mem_be,   4'h0);
    chk("rst_valids",   {bus.if_valid, bus.dm_valid}, 2'b00);
    chk("rst_stall",    bus.stall,    1'b0);
    tick();
    rst = 1'b0;

    // Stray rvalid while idle produces nothing.
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    chk("idle_rvalid_ignored", {bus.if_valid, bus.dm_valid}, 2'b00);
    tick();
    bus.mem_rvalid = 1'b0;

    // IF only at 0x100.
    bus.if_req = 1; bus.if_addr = 32'h100;
    @(negedge clk);
    chk("if_stall_idle", bus.stall,   1'b1);
    chk("if_no_req_yet", bus.mem_req, 1'b0);
    tick();
    serve(1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 32'h0000_0013, 0);
    bus.if_req = 0;
    @(negedge clk);
    chk("if_after_stall", bus.stall,    1'b0);
    chk("if_after_valid", bus.if_valid, 1'b0);
    tick();

    // Simultaneous IF and DM: DM first, then IF.
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2000; bus.dm_be = 4'hF; bus.dm_wdata = 32'h0;
    tick();
    serve(1'b1, 32'h2000, 1'b0, 4'hF, 32'h0, 32'hCAFE_0001, 0);
    bus.dm_req = 0;
    tick();
    serve(1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 0);

    // Both held: four DM grants, then IF, then DM wins again once the count has cleared.
    bus.dm_req = 1; bus.dm_addr = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      tick();
      serve(1'b1, 32'h3000, 1'b0, 4'hF, 32'h0, 32'h3000 + i, 0);
    end
    tick();
    serve(1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 32'h0000_0093, 0);
    tick();
    serve(1'b1, 32'h3000, 1'b0, 4'hF, 32'h0, 32'h0000_3333, 0);
    bus.if_req = 0; bus.dm_req = 0;

    // Grant withheld for 3 cycles; a single transaction results.
    tick();
    bus.dm_req = 1; bus.dm_addr = 32'h44; bus.dm_wdata = 32'h55AA_55AA; bus.dm_be = 4'hC;
    tick();
    serve(1'b1, 32'h44, 1'b0, 4'hC, 32'h55AA_55AA, 32'h0BAD_F00D, 3);
    bus.dm_req = 0;
    @(negedge clk);
    chk("one_xact_req0", bus.mem_req, 1'b0);
    tick();
    @(negedge clk);
    chk("one_xact_req1", bus.mem_req, 1'b0);
    tick();

    // Store.
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_be = 4'b0011;
    tick();
    serve(1'b1, 32'h40, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0, 1);
    bus.dm_req = 0; bus.dm_we = 0;
    tick();

    // rvalid in the same cycle as gnt is ignored; the real response follows.
    bus.if_req = 1; bus.if_addr = 32'h200;
    tick();
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1;
    @(negedge clk);
    chk("gnt_rvalid_same_cycle", bus.if_valid, 1'b0);
    chk("gnt_rvalid_stall",      bus.stall,    1'b1);
    tick();
    bus.mem_gnt = 0; bus.mem_rdata = 32'h2;
    @(negedge clk);
    chk("gnt_rvalid_next_valid", bus.if_valid, 1'b1);
    chk("gnt_rvalid_next_rdata", bus.if_rdata, 32'h2);
    tick();
    bus.mem_rvalid = 0; bus.if_req = 0;
    tick();

    // Reset during RESP abandons the access.
    bus.dm_req = 1; bus.dm_addr = 32'h80; bus.dm_be = 4'hF; bus.dm_wdata = 32'h0;
    tick();
    bus.mem_gnt = 1;
    tick();
    bus.mem_gnt = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_resp_mem_req",  bus.mem_req,  1'b0);
    chk("rst_resp_mem_addr", bus.mem_addr, 32'h0);
    tick();
    bus.dm_req = 0;
    rst = 1'b0;
    bus.mem_rvalid = 1; bus.mem_gnt = 1;
    @(negedge clk);
    chk("late_rvalid_valids", {bus.if_valid, bus.dm_valid}, 2'b00);
    chk("late_gnt_mem_req",   bus.mem_req, 1'b0);
    tick();
    bus.mem_rvalid = 0; bus.mem_gnt = 0;
    @(negedge clk);
    chk("late_idle_stall", bus.stall, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
